// File: rtl/tt_um_ev_multicounter_pkg.sv
// Shared constants for the event multicounter: default sizes, ui_in control
// bit positions, count-mode encoding and the per-channel control payload.
package tt_um_ev_multicounter_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_NCH   = 4;
  localparam int unsigned MAX_NCH   = 4;

  // ui_in control bit positions
  localparam int unsigned CTL_SEL_LSB = 0;
  localparam int unsigned CTL_SEL_MSB = 1;
  localparam int unsigned CTL_EVENT   = 2;
  localparam int unsigned CTL_DIR     = 3;
  localparam int unsigned CTL_LOAD    = 4;
  localparam int unsigned CTL_MODE    = 5;
  localparam int unsigned CTL_CLEAR   = 6;
  localparam int unsigned CTL_VIEW    = 7;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Control bundle broadcast to every channel; only the selected one acts.
  typedef struct packed {
    logic  clear;
    logic  load;
    logic  step;
    logic  dir_up;
    mode_e mode;
  } chan_ctl_t;

endpackage

// File: rtl/ev_counter_channel.sv
// One counter channel: count register plus sticky boundary flag.
// Priority when selected: clear > load > count step. i_ena=0 freezes state.
// Ports: clk, rst_n (async active-low), i_ena, i_sel (channel selected),
//        i_ctl (clear/load/step/dir/mode), i_data (load value),
//        o_count (registered count), o_flag (registered sticky flag).
module ev_counter_channel
  import tt_um_ev_multicounter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ena,
  input  logic             i_sel,
  input  chan_ctl_t        i_ctl,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_count,
  output logic             o_flag
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_count;
  logic             r_flag;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_flag_nxt;

  // Next-state: one action per cycle; boundary hits set the flag in both modes
  always_comb begin
    w_count_nxt = r_count;
    w_flag_nxt  = r_flag;
    if (i_sel) begin
      if (i_ctl.clear) begin
        w_count_nxt = '0;
        w_flag_nxt  = 1'b0;
      end else if (i_ctl.load) begin
        w_count_nxt = i_data;
      end else if (i_ctl.step) begin
        if (i_ctl.dir_up) begin
          if (r_count == CNT_MAX) begin
            w_flag_nxt = 1'b1;
            if (i_ctl.mode == MODE_WRAP) w_count_nxt = '0;
          end else begin
            w_count_nxt = r_count + WIDTH'(1);
          end
        end else begin
          if (r_count == '0) begin
            w_flag_nxt = 1'b1;
            if (i_ctl.mode == MODE_WRAP) w_count_nxt = CNT_MAX;
          end else begin
            w_count_nxt = r_count - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_flag  <= 1'b0;
    end else if (i_ena) begin
      r_count <= w_count_nxt;
      r_flag  <= w_flag_nxt;
    end
  end

  assign o_count = r_count;
  assign o_flag  = r_flag;

endmodule

// File: rtl/tt_um_ev_multicounter.sv
// Multi-channel up/down event counter with wrap/saturate modes and sticky
// boundary flags. uo_out is a combinational view of registered state.
// Optional macro EV_MULTICOUNTER_EDGE_EN: event input goes through a 2-flop
// synchroniser plus delay flop and counts once per rising edge; otherwise
// every clock with the event high counts.
// Ports: clk, rst_n (async active-low), ena (global hold),
//        ui_in  [1:0] sel, [2] event, [3] dir, [4] load, [5] mode,
//               [6] clear, [7] view,
//        uio_in load data, uo_out view output, uio_out/uio_oe tied to 0.
module tt_um_ev_multicounter
  import tt_um_ev_multicounter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NCH   = DEF_NCH
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic [1:0]       w_sel;
  logic             w_sel_valid;
  logic             w_step;
  chan_ctl_t        w_ctl;
  logic [WIDTH-1:0] w_counts [MAX_NCH];
  logic [3:0]       w_flags;

  assign w_sel       = ui_in[CTL_SEL_MSB:CTL_SEL_LSB];
  assign w_sel_valid = (32'(w_sel) < NCH);

`ifdef EV_MULTICOUNTER_EDGE_EN
  logic r_ev_s1;
  logic r_ev_s2;
  logic r_ev_dly;

  // Sync chain; the delay flop turns a synchronised level into a one-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ev_s1  <= 1'b0;
      r_ev_s2  <= 1'b0;
      r_ev_dly <= 1'b0;
    end else if (ena) begin
      r_ev_s1  <= ui_in[CTL_EVENT];
      r_ev_s2  <= r_ev_s1;
      r_ev_dly <= r_ev_s2;
    end
  end

  assign w_step = r_ev_s2 & ~r_ev_dly;
`else
  assign w_step = ui_in[CTL_EVENT];
`endif

  assign w_ctl.clear  = ui_in[CTL_CLEAR];
  assign w_ctl.load   = ui_in[CTL_LOAD];
  assign w_ctl.step   = w_step;
  assign w_ctl.dir_up = ui_in[CTL_DIR];
  assign w_ctl.mode   = mode_e'(ui_in[CTL_MODE]);

  // Instantiate NCH channels; slots beyond NCH read as zero
  for (genvar g = 0; g < MAX_NCH; g++) begin : g_ch
    if (g < NCH) begin : g_used
      ev_counter_channel #(
        .WIDTH (WIDTH)
      ) u_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_ena   (ena),
        .i_sel   (w_sel == 2'(g)),
        .i_ctl   (w_ctl),
        .i_data  (uio_in[WIDTH-1:0]),
        .o_count (w_counts[g]),
        .o_flag  (w_flags[g])
      );
    end else begin : g_unused
      assign w_counts[g] = '0;
      assign w_flags[g]  = 1'b0;
    end
  end

  // View mux: selected count or flag vector; unimplemented channel shows 0
  always_comb begin
    uo_out = 8'h00;
    if (w_sel_valid) begin
      if (ui_in[CTL_VIEW]) uo_out = {4'b0000, w_flags};
      else                 uo_out = 8'(w_counts[w_sel]);
    end
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_ev_multicounter.sv
// Directed bench for tt_um_ev_multicounter (WIDTH=8, NCH=4).
module tb_tt_um_ev_multicounter;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;
  logic       clk;
  logic       rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       ena;
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  tt_um_ev_multicounter #(.WIDTH(8), .NCH(4)) dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mk(input logic [1:0] sel, input logic ev, input logic dir,
                                    input logic ld, input logic md, input logic clr,
                                    input logic vw);
    return {vw, clr, md, ld, dir, ev, sel};
  endfunction

  function automatic vec_t v(input logic e, input logic [7:0] ui, input logic [7:0] uio,
                             input logic [7:0] exp);
    vec_t r;
    r.ena = e; r.ui = ui; r.uio = uio; r.exp = exp;
    return r;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string nm);
    @(negedge clk);
    ena = t.ena; ui_in = t.ui; uio_in = t.uio;
    @(posedge clk);
    #1;
    check(nm, uo_out, t.exp);
  endtask

  initial begin
    logic [7:0] exp_first;
    rst_n = 1'b0; ena = 1'b1; uio_in = 8'h00;
    ui_in = mk(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    #1;
    check("reset_uo_out", uo_out, 8'h00);
    check("tie_uio_out", uio_out, 8'h00);
    check("tie_uio_oe", uio_oe, 8'h00);

    // Release at 12 ns, event held high on ch0 for 5 rising edges
    #11 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
`ifdef EV_MULTICOUNTER_EDGE_EN
    exp_first = 8'h01;
`else
    exp_first = 8'h05;
`endif
    check("first_count_ch0", uo_out, exp_first);
    @(negedge clk);
    ui_in = mk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("idle_hold_ch0", uo_out, exp_first);

`ifndef EV_MULTICOUNTER_EDGE_EN
    // {ena, ui_in, uio_in, uo_out after the edge}
    vecs.push_back(v(1, mk(1,0,1,1,0,0,0), 8'hFE, 8'hFE)); // ch1 load
    vecs.push_back(v(1, mk(1,1,1,0,0,0,0), 8'h00, 8'hFF)); // up, wrap mode
    vecs.push_back(v(1, mk(1,1,1,0,0,0,0), 8'h00, 8'h00)); // wraps, flag1
    vecs.push_back(v(1, mk(1,1,1,0,0,0,0), 8'h00, 8'h01));
    vecs.push_back(v(1, mk(1,0,1,0,0,0,1), 8'h00, 8'h02)); // flag view
    vecs.push_back(v(1, mk(2,0,0,1,1,0,0), 8'h01, 8'h01)); // ch2 load, saturate
    vecs.push_back(v(1, mk(2,1,0,0,1,0,0), 8'h00, 8'h00));
    vecs.push_back(v(1, mk(2,1,0,0,1,0,0), 8'h00, 8'h00)); // held at 0, flag2
    vecs.push_back(v(1, mk(2,1,0,0,1,0,0), 8'h00, 8'h00));
    vecs.push_back(v(1, mk(2,0,0,0,1,0,1), 8'h00, 8'h06));
    vecs.push_back(v(1, mk(2,0,0,0,1,1,0), 8'h00, 8'h00)); // clear ch2
    vecs.push_back(v(1, mk(2,0,0,0,1,0,1), 8'h00, 8'h02));
    vecs.push_back(v(1, mk(3,1,1,1,0,1,0), 8'h55, 8'h00)); // clear wins
    vecs.push_back(v(1, mk(3,1,1,1,0,0,0), 8'h55, 8'h55)); // load wins
    vecs.push_back(v(1, mk(3,1,1,0,0,0,0), 8'h00, 8'h56));
    vecs.push_back(v(1, mk(0,0,1,0,0,0,0), 8'h00, 8'h05)); // ch0 untouched
    vecs.push_back(v(1, mk(0,0,1,1,1,0,0), 8'hFF, 8'hFF));
    vecs.push_back(v(1, mk(0,1,1,0,1,0,0), 8'h00, 8'hFF)); // saturate at max
    vecs.push_back(v(1, mk(0,0,1,0,1,0,1), 8'h00, 8'h03));
    vecs.push_back(v(1, mk(1,0,1,0,1,0,0), 8'h00, 8'h01)); // mode change no effect
    vecs.push_back(v(0, mk(1,1,1,1,0,0,0), 8'hAA, 8'h01)); // ena=0 holds
    vecs.push_back(v(0, mk(1,1,1,1,0,0,0), 8'hAA, 8'h01));
    vecs.push_back(v(0, mk(1,1,1,1,0,1,0), 8'hAA, 8'h01));
    vecs.push_back(v(0, mk(1,1,1,1,0,0,0), 8'hAA, 8'h01));
    vecs.push_back(v(0, mk(1,0,1,0,0,0,1), 8'h00, 8'h03)); // view still tracks
    vecs.push_back(v(1, mk(1,1,1,0,0,0,0), 8'h00, 8'h02)); // resumes
    vecs.push_back(v(1, mk(3,0,0,1,0,0,0), 8'h00, 8'h00));
    vecs.push_back(v(1, mk(3,1,0,0,0,0,0), 8'h00, 8'hFF)); // wrap down
    vecs.push_back(v(1, mk(3,0,0,0,0,0,1), 8'h00, 8'h0B));
    vecs.push_back(v(1, mk(0,0,1,0,0,1,0), 8'h00, 8'h00)); // clear ch0
    vecs.push_back(v(1, mk(0,0,1,0,0,0,1), 8'h00, 8'h0A));
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));
`else
    // Single-cycle pulse counts at the third sampling edge
    @(negedge clk);
    ui_in = mk(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    ui_in = mk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("edge_not_yet", uo_out, 8'h01);
    @(posedge clk);
    #1 check("edge_third", uo_out, 8'h02);
    @(negedge clk);
    ui_in = mk(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1 check("edge_held_once", uo_out, 8'h03);
    apply(v(1, mk(1,0,1,1,0,0,0), 8'hFE, 8'hFE), "edge_ch1_load");
    apply(v(1, mk(0,0,1,0,0,1,0), 8'h00, 8'h00), "edge_ch0_clear");
`endif

    // Reset mid-count on ch0 at 8'h07
    apply(v(1, mk(0,0,1,1,0,0,0), 8'h07, 8'h07), "ch0_load7");
    @(negedge clk);
    ui_in = mk(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("rst_async_ch0", uo_out, 8'h00);
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 2; w++) begin
        ui_in = mk(2'(s), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'(w));
        #1 check($sformatf("rst_view_s%0d_v%0d", s, w), uo_out, 8'h00);
      end
    end
    ui_in = mk(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
`ifdef EV_MULTICOUNTER_EDGE_EN
    #1 check("post_rst_first_edge", uo_out, 8'h00);
`else
    #1 check("post_rst_first_edge", uo_out, 8'h01);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_ev_multicounter.md
TT_UM_EV_MULTICOUNTER -- requirements
Module: tt_um_ev_multicounter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width per channel (legal 4..8).
REQ-002 SHALL have parameter NCH, default 4, number of independent channels (legal 1..4).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port ena  input  1  design enable; 0 freezes all state.
REQ-006 SHALL have port ui_in  input  8  controls: [1:0] chan sel, [2] event, [3] dir (1=up), [4] load, [5] mode (0=wrap, 1=saturate), [6] clear, [7] view (0=count, 1=flags).
REQ-007 SHALL have port uio_in  input  8  load data; bits [WIDTH-1:0] used.
REQ-008 SHALL have port uo_out  output  8  view output.
REQ-009 SHALL have ports uio_out and uio_oe  output  8 each, both tied to 8'h00.

Function
REQ-010 Controls SHALL act only on channel sel = ui_in[1:0]; sel >= NCH SHALL be a no-op and view 8'h00.
REQ-011 Per-cycle priority on selected channel SHALL be clear > load > count; exactly one action per cycle.
REQ-012 Clear SHALL set count to 0 and clear that channel's sticky flag.
REQ-013 Load SHALL set count to uio_in[WIDTH-1:0], flag unchanged; level-sensitive, reloads every cycle held.
REQ-014 Count SHALL step by 1 in the direction of ui_in[3] when a count event is present (see REQ-021/022).
REQ-015 Wrap mode: up at 2^WIDTH-1 SHALL go to 0; down at 0 SHALL go to 2^WIDTH-1; flag set.
REQ-016 Saturate mode: up at max / down at 0 SHALL hold value; flag set.
REQ-017 Sticky flag SHALL stay set until clear or reset; mode change SHALL NOT alter counts or flags.
REQ-018 ena=0 SHALL hold all counters, flags and event-sync registers; outputs still track view.
REQ-019 uo_out (view=0) SHALL be selected count zero-extended to 8 bits; (view=1) SHALL be {4'b0, flags[3:0]}, unused channels 0.
REQ-020 uo_out SHALL be combinational from registered state: new value visible the cycle after the updating edge.

Configuration
REQ-021 With EV_MULTICOUNTER_EDGE_EN defined: ui_in[2] SHALL pass a 2-flop synchroniser plus delay flop; one count per rising edge of the event, applied at the third rising clk edge at which ui_in[2] is sampled high (first sampling edge counts as 1); held-high event counts once.
REQ-022 Without the macro: no synchroniser; every clk edge with ui_in[2]=1 SHALL count (one per cycle).

Reset
REQ-023 rst_n low SHALL asynchronously clear all counters, flags and sync/delay registers; uo_out=8'h00 during reset.
REQ-024 Reset mid-count or mid-load SHALL discard the operation; first update possible on first rising edge after rst_n rises.

Structure
REQ-025 Package tt_um_ev_multicounter_pkg SHALL hold control-bit index constants, mode encodings and WIDTH/NCH defaults.
REQ-026 Sub-module ev_counter_channel SHALL implement one channel (count, flag, clear/load/count priority, wrap/saturate); top instantiates NCH via generate.

Verification (WIDTH=8, NCH=4)
REQ-027 Reset 12 ns, ena=1, sel=0, dir=1, event=1 for 5 cycles (no macro) -> uo_out=5; with macro -> uo_out=1.
REQ-028 Load 8'hFE ch1, then 3 up events, wrap mode -> 8'hFE,8'hFF,8'h00,8'h01; view=1 -> uo_out=8'h02.
REQ-029 ch2 saturate, load 8'h01, 3 down events -> 8'h00 held, flag bit2 set; clear -> count 0, flag bit2 0.
REQ-030 clear+load+event same cycle on ch3 with uio_in=8'h55 -> 0; load+event -> 8'h55.
REQ-031 ena=0 with event and load active 4 cycles -> counts/flags unchanged; ena=1 resumes.
REQ-032 rst_n low mid-count on ch0 at 8'h07 -> uo_out 8'h00 immediately, flags 0, other channels 0.
